// File: rtl/mii_rx_deframer_if.sv
// MII receive pins plus the deframed byte stream and frame status.
// slave is the deframer side; master is the PHY/consumer side.
interface mii_rx_deframer_if;
    logic [3:0]  rxd;
    logic        rx_dv;
    logic        rx_er;
    logic [7:0]  data;
    logic        valid;
    logic        sof;
    logic        done;
    logic [10:0] len;
    logic        good;
    logic        crc_ok;
    logic        err_code;
    logic        odd;
    logic        runt;
    logic        long;
    logic [15:0] frames_good;
    logic [15:0] frames_bad;

    modport slave (
        input  rxd, rx_dv, rx_er,
        output data, valid, sof, done, len,
        output good, crc_ok, err_code, odd, runt, long,
        output frames_good, frames_bad
    );

    modport master (
        output rxd, rx_dv, rx_er,
        input  data, valid, sof, done, len,
        input  good, crc_ok, err_code, odd, runt, long,
        input  frames_good, frames_bad
    );
endinterface

// File: rtl/mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, packs nibbles into bytes,
// checks the Ethernet FCS and counts good and bad frames.
module mii_rx_deframer #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic              clk,
    input  logic              rst,
    mii_rx_deframer_if.slave  bus
);
    localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
    localparam logic [31:0] POLY    = 32'hEDB88320;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        WAIT_IDLE, IDLE, PREAMBLE, DATA, DROP
    } state_t;

    state_t      state, state_n;
    logic        phase, phase_n;
    logic [3:0]  lo, lo_n;
    logic [10:0] cnt, cnt_n;
    logic [31:0] crc, crc_n;
    logic        err, err_n;

    logic [7:0]  data_q, data_n;
    logic        valid_q, valid_n;
    logic        sof_q, sof_n;
    logic        done_q, done_n;
    logic [10:0] len_q, len_n;
    logic        good_q, good_n;
    logic        crc_ok_q, crc_ok_n;
    logic        err_code_q, err_code_n;
    logic        odd_q, odd_n;
    logic        runt_q, runt_n;
    logic        long_q, long_n;
    logic [15:0] fg_q, fg_n;
    logic [15:0] fb_q, fb_n;

    logic [7:0]  byte_w;
    logic [10:0] cnt_inc;
    logic        ok_w, runt_w, long_w, good_w;

    // Reflected CRC-32, LSB of each byte first.
    function automatic logic [31:0] crc_upd(
        input logic [31:0] c,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r >> 1) ^ ((r[0] ^ b[i]) ? POLY : 32'h0);
        end
        return r;
    endfunction

    assign byte_w  = {bus.rxd, lo};
    assign cnt_inc = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
    assign ok_w    = (crc == RESIDUE);
    assign runt_w  = (cnt < MIN_L);
    assign long_w  = (cnt > MAX_L);
    assign good_w  = ok_w & ~err & ~phase & ~runt_w & ~long_w;

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        lo_n       = lo;
        cnt_n      = cnt;
        crc_n      = crc;
        err_n      = err;
        data_n     = data_q;
        valid_n    = 1'b0;
        sof_n      = 1'b0;
        done_n     = 1'b0;
        len_n      = len_q;
        good_n     = good_q;
        crc_ok_n   = crc_ok_q;
        err_code_n = err_code_q;
        odd_n      = odd_q;
        runt_n     = runt_q;
        long_n     = long_q;
        fg_n       = fg_q;
        fb_n       = fb_q;

        unique case (state)
            WAIT_IDLE: begin
                if (!bus.rx_dv) state_n = IDLE;
            end
            IDLE: begin
                if (bus.rx_dv) begin
                    state_n = (bus.rxd == 4'h5) ? PREAMBLE : DROP;
                end
            end
            PREAMBLE: begin
                if (!bus.rx_dv) begin
                    state_n = IDLE;
                end else if (bus.rxd == 4'hD) begin
                    state_n = DATA;
                    phase_n = 1'b0;
                    cnt_n   = 11'd0;
                    crc_n   = 32'hFFFFFFFF;
                    err_n   = 1'b0;
                end else if (bus.rxd != 4'h5) begin
                    state_n = DROP;
                end
            end
            DATA: begin
                if (!bus.rx_dv) begin
                    state_n    = IDLE;
                    done_n     = 1'b1;
                    len_n      = cnt;
                    crc_ok_n   = ok_w;
                    err_code_n = err;
                    odd_n      = phase;
                    runt_n     = runt_w;
                    long_n     = long_w;
                    good_n     = good_w;
                    if (good_w) begin
                        if (fg_q != 16'hFFFF) fg_n = fg_q + 16'd1;
                    end else begin
                        if (fb_q != 16'hFFFF) fb_n = fb_q + 16'd1;
                    end
                end else begin
                    if (bus.rx_er) err_n = 1'b1;
                    if (!phase) begin
                        lo_n    = bus.rxd;
                        phase_n = 1'b1;
                    end else begin
                        phase_n = 1'b0;
                        cnt_n   = cnt_inc;
                        crc_n   = crc_upd(crc, byte_w);
                        // Oversize frames are still counted, not emitted.
                        if (cnt_inc <= MAX_L) begin
                            valid_n = 1'b1;
                            data_n  = byte_w;
                            sof_n   = (cnt_inc == 11'd1);
                        end
                    end
                end
            end
            DROP: begin
                if (!bus.rx_dv) state_n = IDLE;
            end
            default: state_n = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAIT_IDLE;
            phase      <= 1'b0;
            lo         <= 4'h0;
            cnt        <= 11'd0;
            crc        <= 32'hFFFFFFFF;
            err        <= 1'b0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            done_q     <= 1'b0;
            len_q      <= 11'd0;
            good_q     <= 1'b0;
            crc_ok_q   <= 1'b0;
            err_code_q <= 1'b0;
            odd_q      <= 1'b0;
            runt_q     <= 1'b0;
            long_q     <= 1'b0;
            fg_q       <= 16'h0000;
            fb_q       <= 16'h0000;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            lo         <= lo_n;
            cnt        <= cnt_n;
            crc        <= crc_n;
            err        <= err_n;
            data_q     <= data_n;
            valid_q    <= valid_n;
            sof_q      <= sof_n;
            done_q     <= done_n;
            len_q      <= len_n;
            good_q     <= good_n;
            crc_ok_q   <= crc_ok_n;
            err_code_q <= err_code_n;
            odd_q      <= odd_n;
            runt_q     <= runt_n;
            long_q     <= long_n;
            fg_q       <= fg_n;
            fb_q       <= fb_n;
        end
    end

    assign bus.data        = data_q;
    assign bus.valid       = valid_q;
    assign bus.sof         = sof_q;
    assign bus.done        = done_q;
    assign bus.len         = len_q;
    assign bus.good        = good_q;
    assign bus.crc_ok      = crc_ok_q;
    assign bus.err_code    = err_code_q;
    assign bus.odd         = odd_q;
    assign bus.runt        = runt_q;
    assign bus.long        = long_q;
    assign bus.frames_good = fg_q;
    assign bus.frames_bad  = fb_q;
endmodule

// File: tb/tb_mii_rx_deframer.sv
// Scoreboard bench for mii_rx_deframer: stimulus queues expected bytes
// and frame status, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_mii_rx_deframer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    mii_rx_deframer_if bus();

    mii_rx_deframer #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       sof;
    } eb_t;

    typedef struct {
        logic [10:0] len;
        logic        crc_ok;
        logic        err;
        logic        odd;
        logic        runt;
        logic        lng;
        logic        good;
        logic [15:0] fg;
        logic [15:0] fb;
    } ed_t;

    eb_t        qb[$];
    ed_t        qd[$];
    logic [7:0] frm[$];
    int         n_pass  = 0;
    int         n_total = 0;
    int         exp_fg  = 0;
    int         exp_fb  = 0;
    logic       cnt_pend = 1'b0;
    logic [15:0] cfg, cfb;
    eb_t        mb;
    ed_t        md;

    function void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    function automatic ed_t mk(int len, bit ok, bit er, bit od,
                               bit ru, bit lg, bit gd);
        ed_t e;
        e.len = 11'(len); e.crc_ok = ok; e.err = er; e.odd = od;
        e.runt = ru; e.lng = lg; e.good = gd; e.fg = 0; e.fb = 0;
        return e;
    endfunction

    // Monitor: every VALID and DONE must match the head of its queue.
    always @(negedge clk) begin
        if (cnt_pend) begin
            chk("frames_good", bus.frames_good, cfg);
            chk("frames_bad", bus.frames_bad, cfb);
            cnt_pend = 1'b0;
        end
        if (bus.valid) begin
            chk("byte_expected", 32'(qb.size() > 0), 1);
            if (qb.size() > 0) begin
                mb = qb.pop_front();
                chk("data", bus.data, mb.d);
                chk("sof", bus.sof, mb.sof);
            end
        end
        if (bus.done) begin
            chk("done_expected", 32'(qd.size() > 0), 1);
            chk("done_with_valid", bus.valid, 0);
            if (qd.size() > 0) begin
                md = qd.pop_front();
                chk("len", bus.len, md.len);
                chk("crc_ok", bus.crc_ok, md.crc_ok);
                chk("err_code", bus.err_code, md.err);
                chk("odd", bus.odd, md.odd);
                chk("runt", bus.runt, md.runt);
                chk("long", bus.long, md.lng);
                chk("good", bus.good, md.good);
                cfg = md.fg;
                cfb = md.fb;
                cnt_pend = 1'b1;
            end
        end
    end

    task automatic nib(input logic [3:0] n, input logic dv, input logic er);
        @(negedge clk);
        bus.rxd   = n;
        bus.rx_dv = dv;
        bus.rx_er = er;
    endtask

    task automatic idle(input int n);
        repeat (n) nib(4'h0, 1'b0, 1'b0);
    endtask

    task automatic build(input int n);
        logic [31:0] c;
        logic [7:0]  b;
        frm.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++) begin
            b = i[7:0];
            frm.push_back(b);
            c = c ^ {24'h0, b};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
        frm.push_back(c[23:16]);
        frm.push_back(c[31:24]);
    endtask

    task automatic preamble();
        repeat (15) nib(4'h5, 1'b1, 1'b0);
        nib(4'hD, 1'b1, 1'b0);
    endtask

    task automatic send(input int flip, input int er_at, input bit extra,
                        input ed_t ex, input int gap);
        logic [7:0] b;
        preamble();
        for (int i = 0; i < frm.size(); i++) begin
            b = frm[i];
            if (i == flip) b = b ^ 8'h04;
            nib(b[3:0], 1'b1, 1'(i == er_at));
            if (i < 1518) qb.push_back('{b, 1'(i == 0)});
            nib(b[7:4], 1'b1, 1'b0);
        end
        if (extra) nib(4'hA, 1'b1, 1'b0);
        if (ex.good) exp_fg++;
        else exp_fb++;
        ex.fg = 16'(exp_fg);
        ex.fb = 16'(exp_fb);
        qd.push_back(ex);
        nib(4'h0, 1'b0, 1'b0);
        idle(gap);
    endtask

    task automatic drained(input string nm);
        #1;
        chk({nm, "_bytes_left"}, qb.size(), 0);
        chk({nm, "_done_left"}, qd.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.rxd   = 4'h0;
        bus.rx_dv = 1'b0;
        bus.rx_er = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", bus.valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_data", bus.data, 0);
        chk("rst_len", bus.len, 0);
        chk("rst_good", bus.good, 0);
        chk("rst_fg", bus.frames_good, 0);
        chk("rst_fb", bus.frames_bad, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        build(64);
        send(-1, -1, 0, mk(64, 1, 0, 0, 0, 0, 1), 3);
        drained("good64");

        send(10, -1, 0, mk(64, 0, 0, 0, 0, 0, 0), 1);
        send(-1, 20, 0, mk(64, 1, 1, 0, 0, 0, 0), 3);
        drained("flip_rxer");

        send(-1, -1, 1, mk(64, 1, 0, 1, 0, 0, 0), 3);
        drained("odd");

        nib(4'h5, 1'b1, 1'b0);
        nib(4'h5, 1'b1, 1'b0);
        nib(4'h3, 1'b1, 1'b0);
        repeat (20) nib(4'h7, 1'b1, 1'b0);
        idle(1);
        send(-1, -1, 0, mk(64, 1, 0, 0, 0, 0, 1), 3);
        drained("bad_pre");

        preamble();
        for (int i = 0; i < 30; i++) begin
            nib(frm[i][3:0], 1'b1, 1'b0);
            qb.push_back('{frm[i], 1'(i == 0)});
            nib(frm[i][7:4], 1'b1, 1'b0);
        end
        nib(frm[30][3:0], 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        bus.rxd = frm[30][7:4];
        exp_fg = 0;
        exp_fb = 0;
        @(negedge clk);
        rst = 1'b0;
        bus.rxd = 4'h1;
        #1;
        chk("midrst_fg", bus.frames_good, 0);
        chk("midrst_fb", bus.frames_bad, 0);
        chk("midrst_valid", bus.valid, 0);
        for (int i = 31; i < 64; i++) begin
            nib(frm[i][3:0], 1'b1, 1'b0);
            nib(frm[i][7:4], 1'b1, 1'b0);
        end
        idle(1);
        send(-1, -1, 0, mk(64, 1, 0, 0, 0, 0, 1), 3);
        drained("midrst");

        build(40);
        send(-1, -1, 0, mk(40, 1, 0, 0, 1, 0, 0), 3);
        drained("runt");

        build(1600);
        send(-1, -1, 0, mk(1600, 1, 0, 0, 0, 1, 0), 3);
        drained("long");

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
